// File: rtl/profile_window_ctrl.sv
// Custom-instruction controller that runs one timed measurement window on a profiling
// counter block: reset+enable, count N cycles, disable, then read masked counters back.
module profile_window_ctrl #(
   parameter logic [7:0] customId = 8'd9,
   parameter logic [7:0] profId   = 8'd8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic        profStart,
   output logic [7:0]  profCiN,
   output logic [31:0] profValueA,
   output logic [31:0] profValueB,
   input  logic        profDone,
   input  logic [31:0] profResult
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StWindow   = 3'd2,
      StStop     = 3'd3,
      StReadback = 3'd4
   } state_e;

   localparam logic [1:0] CmdArm    = 2'd0;
   localparam logic [1:0] CmdStatus = 2'd1;
   localparam logic [1:0] CmdRead   = 2'd2;
   localparam logic [1:0] CmdAbort  = 2'd3;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] n_q, n_d;
   logic [3:0]  mask_q, mask_d;
   logic [3:0]  pend_q, pend_d;
   logic [31:0] snap_q [4];
   logic [31:0] snap_d [4];
   logic        snap_valid_q, snap_valid_d;
   logic        abort_q, abort_d;
   logic        gap_q, gap_d;

   logic        hit;
   logic [1:0]  cmd;
   logic        arm_ok;
   logic        abort_cmd;
   logic        prof_xfer;
   logic [1:0]  rb_idx;
   logic [31:0] status_word;
   logic        unused_bits;

   assign unused_bits = ^{valueA[31:8], valueA[3:2]};

   assign hit       = start && (ciN == customId);
   assign cmd       = valueA[1:0];
   assign arm_ok    = (state_q == StIdle) && (valueB != 32'd0) && (valueA[7:4] != 4'd0);
   assign abort_cmd = hit && (cmd == CmdAbort);
   assign prof_xfer = profStart && profDone;

   assign status_word = {24'd0, snap_valid_q, state_q != StIdle, 3'd0, state_q};

   // Lowest pending mask bit selects the counter being read back.
   always_comb begin
      rb_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pend_q[i]) rb_idx = 2'(i);
      end
   end

   always_comb begin
      done   = hit;
      result = 32'd0;
      if (hit) begin
         unique case (cmd)
            CmdArm:    result = arm_ok ? 32'd0 : 32'd1;
            CmdStatus: result = status_word;
            CmdRead:   result = snap_q[valueB[1:0]];
            default:   result = 32'd0;
         endcase
      end
   end

   // gap_q forces one idle cycle after every completed counter transaction.
   always_comb begin
      profStart  = 1'b0;
      profValueA = 32'd0;
      profValueB = 32'd0;
      unique case (state_q)
         StStart: begin
            profStart  = !gap_q;
            profValueB = {20'd0, mask_q, 4'd0, mask_q};
         end
         StStop: begin
            profStart  = !gap_q;
            profValueB = {24'd0, mask_q, 4'd0};
         end
         StReadback: begin
            profStart  = !gap_q;
            profValueA = {30'd0, rb_idx};
         end
         default: ;
      endcase
      if (!profStart) begin
         profValueA = 32'd0;
         profValueB = 32'd0;
      end
      profCiN = profStart ? profId : 8'd0;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      n_d          = n_q;
      mask_d       = mask_q;
      pend_d       = pend_q;
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      abort_d      = abort_q;
      gap_d        = prof_xfer;
      unique case (state_q)
         StIdle: begin
            if (hit && (cmd == CmdArm) && arm_ok) begin
               state_d      = StStart;
               n_d          = valueB;
               mask_d       = valueA[7:4];
               snap_valid_d = 1'b0;
               abort_d      = 1'b0;
            end
         end
         StStart: begin
            // An abort here waits for the in-flight start word so the counter block
            // never sees its control word change mid-transaction.
            if (prof_xfer) begin
               state_d = (abort_q || abort_cmd) ? StStop : StWindow;
               abort_d = abort_q || abort_cmd;
               cnt_d   = n_q;
            end else if (abort_cmd) begin
               abort_d = 1'b1;
            end
         end
         StWindow: begin
            if (abort_cmd) begin
               state_d = StStop;
               abort_d = 1'b1;
            end else if (cnt_q == 32'd1) begin
               state_d = StStop;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         StStop: begin
            if (prof_xfer) begin
               state_d = abort_q ? StIdle : StReadback;
               pend_d  = abort_q ? 4'd0 : mask_q;
            end
         end
         StReadback: begin
            if (abort_cmd) begin
               state_d = StIdle;
               pend_d  = 4'd0;
            end else if (prof_xfer) begin
               snap_d[rb_idx] = profResult;
               pend_d[rb_idx] = 1'b0;
               if ((pend_q & ~(4'b0001 << rb_idx)) == 4'd0) begin
                  state_d      = StIdle;
                  snap_valid_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= 32'd0;
         n_q          <= 32'd0;
         mask_q       <= 4'd0;
         pend_q       <= 4'd0;
         snap_valid_q <= 1'b0;
         abort_q      <= 1'b0;
         gap_q        <= 1'b0;
         for (int i = 0; i < 4; i++) snap_q[i] <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         n_q          <= n_d;
         mask_q       <= mask_d;
         pend_q       <= pend_d;
         snap_valid_q <= snap_valid_d;
         abort_q      <= abort_d;
         gap_q        <= gap_d;
         for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
      end
   end

endmodule

// File: doc/profile_window_ctrl.md
Name: profile_window_ctrl

Overview:
- Custom-instruction controller that sequences a profileCi-style counter block: host arms a measurement window, block auto-issues counter reset/enable, times the window, issues disable, reads back selected counters into snapshot registers.
- Sits on CPU custom-instruction bus (own customId) and acts as the sole CI master of one profiling counter block.

Parameters:
customId, 8'd9, CI id this block answers to
profId, 8'd8, CI id driven on profCiN toward the counter block

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  host CI start
ciN  in  8  host CI id
valueA  in  32  [1:0] command, [7:4] counter mask
valueB  in  32  window length (ARM) or snapshot index in [1:0] (READ)
done  out  1  host CI done
result  out  32  host CI result
profStart  out  1  CI start toward counter block
profCiN  out  8  CI id toward counter block
profValueA  out  32  counter select, [1:0] used
profValueB  out  32  control word: [3:0] enable, [7:4] disable, [11:8] reset
profDone  in  1  counter block done
profResult  in  32  counter block result

Behaviour:
- Host side: hit = start && ciN==customId. done = hit, combinational, every command (0-cycle latency). result = 0 whenever !hit.
- Commands valueA[1:0]: 0 ARM, 1 STATUS, 2 READ, 3 ABORT.
- ARM accepted only in IDLE with valueB!=0 and mask!=0: result 0, latch N=valueB, mask, clear snapValid, go START. Otherwise result 32'h1, no state change.
- STATUS result: {24'b0, snapValid, busy, 3'b0, state[2:0]}; busy = state!=IDLE.
- READ result: snapshot[valueB[1:0]] (any state; stale data allowed).
- ABORT: in START/WINDOW go STOP (disable still issued, no readback, snapValid stays 0); in READBACK go IDLE; in IDLE/STOP no effect. result 0.
- States: IDLE(0), START(1), WINDOW(2), STOP(3), READBACK(4).
- Profiler transaction: profStart high with stable profCiN=profId, profValueA, profValueB; held until profDone sampled high at a rising edge; profStart low the next cycle; profResult captured on the profDone edge. profDone in same cycle as profStart is legal (one-cycle transaction). profCiN=0, profValueA/B=0 when profStart low.
- START: word = {20'b0, mask, 4'b0, mask} (reset+enable). On profDone -> WINDOW, load down-counter with N.
- WINDOW: exactly N cycles, decrement each cycle; at 1 -> STOP. 32-bit count, no wrap.
- STOP: word = {24'b0, mask, 4'b0}. On profDone -> READBACK (or IDLE if aborted).
- READBACK: for each set mask bit, ascending index i: profValueA=i, profValueB=0; store profResult in snapshot[i]. Unmasked snapshots untouched. After last -> IDLE, snapValid=1.
- ARM hit in same cycle as READBACK completion: rejected (state not yet IDLE).
- Reset (async assert): state IDLE, snapshots 0, snapValid 0, profStart 0, all prof outputs 0; done/result follow host inputs (combinational) but STATUS reads 0. Reset mid-transaction abandons it; counter block not cleaned up.

Test Plan:
- Reset, STATUS with ciN=9 -> done=1, result=0; ciN=8'h11 -> done=0, result=0.
- ARM mask=4'b0001, N=10, profDone tied to profStart -> result 0; profValueB=32'h101 for 1 cycle, WINDOW exactly 10 cycles, profValueB=32'h10, readback idx0; model returns 32'd12 -> READ idx0 =12, STATUS snapValid=1, state 0.
- ARM mask=4'b0110, profDone delayed 3 cycles -> profStart held 3 cycles each transaction, readback order idx1 then idx2, snapshot[0] keeps 12.
- ARM while busy, ARM with N=0, ARM with mask=0 -> result 32'h1, STATUS unchanged.
- ABORT in WINDOW -> STOP issued with disable word, IDLE next, snapValid=0, no readback transactions.
- Reset asserted during STOP with profStart high -> profStart 0 immediately, STATUS=0, snapshots 0.
